// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl -- multi-cycle control unit for the second-generation MIPS core.
//
// Sequences FETCH -> DCD -> EXE -> MEM -> WB (plus BR, JMP and ERR) and shares
// one ALU and one memory port. Memory accesses use a req/rdy handshake that is
// guarded by a watchdog. An access that waits TIMEOUT cycles without rdy traps
// the machine into ERR. A trap can be left only through reset.
//
// Parameters:
//   TIMEOUT  maximum wait cycles per memory access before trapping (0 = off)
//   CNTW     watchdog counter width, 2**CNTW > TIMEOUT
//
// Ports:
//   clk      core clock, rising edge
//   rst      asynchronous, active-low reset
//   Op       IR[31:26], stable from DCD until the next fetch handshake
//   Funct    IR[5:0]
//   Zero     ALU zero flag (beq decision)
//   mem_rdy  memory completes the current access this cycle
//   mem_req  memory access request
//   MemW     store qualifier, valid with mem_req
//   IRWr     load instruction register
//   PCWr     write PC
//   PCSrc    00 PC+4, 01 branch target, 10 jump target, 11 RD1 (jr)
//   RegW     register-file write
//   RegDst   00 rd, 01 rt, 10 $31
//   WDSel    00 ALU result, 01 memory data, 10 PC+4
//   ALUSrcB  0 RD2, 1 Imm32
//   EXTOp    0 zero-extend, 1 sign-extend, 2 imm<<16
//   ALUOp    0 NOP 1 ADD 2 SUB 3 AND 4 OR 5 SLT 6 SLL 7 SRL 8 LUI
//   state    current state (debug)
//   trap     sticky error flag
// -----------------------------------------------------------------------------
module mc_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNTW    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_rdy,
    output logic       mem_req,
    output logic       MemW,
    output logic       IRWr,
    output logic       PCWr,
    output logic [1:0] PCSrc,
    output logic       RegW,
    output logic [1:0] RegDst,
    output logic [1:0] WDSel,
    output logic       ALUSrcB,
    output logic [1:0] EXTOp,
    output logic [4:0] ALUOp,
    output logic [2:0] state,
    output logic       trap
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_DCD   = 3'd1,
        S_EXE   = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_BR    = 3'd5,
        S_JMP   = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2A;

    // ALU operations
    localparam logic [4:0] ALU_NOP = 5'd0;
    localparam logic [4:0] ALU_ADD = 5'd1;
    localparam logic [4:0] ALU_SUB = 5'd2;
    localparam logic [4:0] ALU_AND = 5'd3;
    localparam logic [4:0] ALU_OR  = 5'd4;
    localparam logic [4:0] ALU_SLT = 5'd5;
    localparam logic [4:0] ALU_SLL = 5'd6;
    localparam logic [4:0] ALU_SRL = 5'd7;
    localparam logic [4:0] ALU_LUI = 5'd8;

    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_HIGH = 2'd2;

    localparam bit            WD_EN    = (TIMEOUT != 0);
    localparam logic [CNTW-1:0] WD_LIMIT = CNTW'(TIMEOUT);

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_inc;
    logic            trap_q;

    // -------------------------------------------------------------------------
    // Instruction classification
    // -------------------------------------------------------------------------
    logic is_rtype, is_r_alu, is_jr;
    logic is_imm, is_lw, is_sw, is_mem;
    logic is_beq, is_j, is_jal;

    assign is_rtype = (Op == OP_RTYPE);
    assign is_r_alu = is_rtype && ((Funct == F_ADDU) || (Funct == F_SUBU) ||
                                   (Funct == F_AND)  || (Funct == F_OR)   ||
                                   (Funct == F_SLT)  || (Funct == F_SLL)  ||
                                   (Funct == F_SRL));
    assign is_jr    = is_rtype && (Funct == F_JR);
    assign is_imm   = (Op == OP_ADDI) || (Op == OP_ORI) || (Op == OP_LUI);
    assign is_lw    = (Op == OP_LW);
    assign is_sw    = (Op == OP_SW);
    assign is_mem   = is_lw || is_sw;
    assign is_beq   = (Op == OP_BEQ);
    assign is_j     = (Op == OP_J);
    assign is_jal   = (Op == OP_JAL);

    // ALU controls for the current instruction; driven in EXE and held through
    // MEM and WB so the datapath result stays stable until it is written.
    logic [4:0] alu_dec;
    logic       srcb_dec;
    logic [1:0] ext_dec;

    always_comb begin
        alu_dec  = ALU_NOP;
        srcb_dec = 1'b0;
        ext_dec  = EXT_ZERO;
        if (is_rtype) begin
            unique case (Funct)
                F_ADDU:  alu_dec = ALU_ADD;
                F_SUBU:  alu_dec = ALU_SUB;
                F_AND:   alu_dec = ALU_AND;
                F_OR:    alu_dec = ALU_OR;
                F_SLT:   alu_dec = ALU_SLT;
                F_SLL:   alu_dec = ALU_SLL;
                F_SRL:   alu_dec = ALU_SRL;
                default: alu_dec = ALU_NOP;
            endcase
        end else begin
            unique case (Op)
                OP_ADDI, OP_LW, OP_SW: begin
                    alu_dec  = ALU_ADD;
                    srcb_dec = 1'b1;
                    ext_dec  = EXT_SIGN;
                end
                OP_ORI: begin
                    alu_dec  = ALU_OR;
                    srcb_dec = 1'b1;
                    ext_dec  = EXT_ZERO;
                end
                OP_LUI: begin
                    alu_dec  = ALU_LUI;
                    srcb_dec = 1'b1;
                    ext_dec  = EXT_HIGH;
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Watchdog
    // -------------------------------------------------------------------------
    // A cycle is "waiting" when the port is requested but not answered. The
    // trap fires on the wait cycle that brings the count to TIMEOUT; a rdy in
    // that same cycle means it is not a wait cycle, so the access completes.
    logic access, waiting, timeout_hit;

    assign access      = (state_q == S_FETCH) || (state_q == S_MEM);
    assign waiting     = access && !mem_rdy;
    assign cnt_inc     = cnt_q + 1'b1;
    assign timeout_hit = WD_EN && waiting && (cnt_inc == WD_LIMIT);

    // -------------------------------------------------------------------------
    // Next state and Moore outputs (plus the rdy-qualified fetch strobes)
    // -------------------------------------------------------------------------
    logic       mem_req_c, memw_c, irwr_c, pcwr_c, regw_c, srcb_c;
    logic [1:0] pcsrc_c, regdst_c, wdsel_c, ext_c;
    logic [4:0] alu_c;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        mem_req_c = 1'b0;
        memw_c    = 1'b0;
        irwr_c    = 1'b0;
        pcwr_c    = 1'b0;
        pcsrc_c   = 2'b00;
        regw_c    = 1'b0;
        regdst_c  = 2'b00;
        wdsel_c   = 2'b00;
        srcb_c    = 1'b0;
        ext_c     = EXT_ZERO;
        alu_c     = ALU_NOP;

        unique case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                if (mem_rdy) begin
                    irwr_c  = 1'b1;
                    pcwr_c  = 1'b1;
                    state_d = S_DCD;
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end
            end

            S_DCD: begin
                if (is_r_alu || is_imm || is_mem) state_d = S_EXE;
                else if (is_beq)                   state_d = S_BR;
                else if (is_j || is_jal || is_jr)  state_d = S_JMP;
                else                               state_d = S_ERR;
            end

            S_EXE: begin
                alu_c   = alu_dec;
                srcb_c  = srcb_dec;
                ext_c   = ext_dec;
                state_d = is_mem ? S_MEM : S_WB;
            end

            S_MEM: begin
                mem_req_c = 1'b1;
                memw_c    = is_sw;
                alu_c     = alu_dec;
                srcb_c    = srcb_dec;
                ext_c     = ext_dec;
                if (mem_rdy)          state_d = is_lw ? S_WB : S_FETCH;
                else if (timeout_hit) state_d = S_ERR;
            end

            S_WB: begin
                regw_c   = 1'b1;
                alu_c    = alu_dec;
                srcb_c   = srcb_dec;
                ext_c    = ext_dec;
                regdst_c = is_rtype ? 2'b00 : 2'b01;
                wdsel_c  = is_lw ? 2'b01 : 2'b00;
                state_d  = S_FETCH;
            end

            S_BR: begin
                alu_c  = ALU_SUB;
                srcb_c = 1'b0;
                if (Zero) begin
                    pcwr_c  = 1'b1;
                    pcsrc_c = 2'b01;
                end
                state_d = S_FETCH;
            end

            S_JMP: begin
                pcwr_c  = 1'b1;
                pcsrc_c = is_jr ? 2'b11 : 2'b10;
                if (is_jal) begin
                    regw_c   = 1'b1;
                    regdst_c = 2'b10;
                    wdsel_c  = 2'b10;
                end
                state_d = S_FETCH;
            end

            S_ERR: state_d = S_ERR;

            default: state_d = S_ERR;
        endcase
    end

    // -------------------------------------------------------------------------
    // State, watchdog counter and sticky trap
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            // Any state change (entry to FETCH or MEM included) restarts the
            // count; it only advances while the current access is waiting.
            if (state_d != state_q)
                cnt_q <= '0;
            else if (WD_EN && waiting)
                cnt_q <= cnt_inc;
            if (state_d == S_ERR)
                trap_q <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: forced to 0 for as long as reset is held, so an access in
    // flight is dropped in the same instant reset asserts.
    // -------------------------------------------------------------------------
    assign mem_req = rst & mem_req_c;
    assign MemW    = rst & memw_c;
    assign IRWr    = rst & irwr_c;
    assign PCWr    = rst & pcwr_c;
    assign PCSrc   = rst ? pcsrc_c  : 2'b00;
    assign RegW    = rst & regw_c;
    assign RegDst  = rst ? regdst_c : 2'b00;
    assign WDSel   = rst ? wdsel_c  : 2'b00;
    assign ALUSrcB = rst & srcb_c;
    assign EXTOp   = rst ? ext_c    : 2'b00;
    assign ALUOp   = rst ? alu_c    : 5'd0;
    assign state   = rst ? state_q  : 3'd0;
    assign trap    = rst & trap_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl -- directed test of mc_ctrl with a 4-cycle watchdog.
// Each cycle the bench drives Op/Funct/Zero/mem_rdy just after the rising
// edge, lets the outputs settle and compares the whole output bundle with a
// hand-written expected vector.
// -----------------------------------------------------------------------------
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       mem_rdy;
    logic       mem_req, MemW, IRWr, PCWr, RegW, ALUSrcB, trap;
    logic [1:0] PCSrc, RegDst, WDSel, EXTOp;
    logic [4:0] ALUOp;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mc_ctrl #(.TIMEOUT(4), .CNTW(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .Op      (Op),
        .Funct   (Funct),
        .Zero    (Zero),
        .mem_rdy (mem_rdy),
        .mem_req (mem_req),
        .MemW    (MemW),
        .IRWr    (IRWr),
        .PCWr    (PCWr),
        .PCSrc   (PCSrc),
        .RegW    (RegW),
        .RegDst  (RegDst),
        .WDSel   (WDSel),
        .ALUSrcB (ALUSrcB),
        .EXTOp   (EXTOp),
        .ALUOp   (ALUOp),
        .state   (state),
        .trap    (trap)
    );

    // Output bundle: mem_req MemW IRWr PCWr PCSrc RegW RegDst WDSel ALUSrcB
    //                EXTOp ALUOp state trap  (23 bits)
    logic [22:0] outs;
    assign outs = {mem_req, MemW, IRWr, PCWr, PCSrc, RegW, RegDst, WDSel,
                   ALUSrcB, EXTOp, ALUOp, state, trap};

    function automatic logic [22:0] ev(
        input logic mreq, input logic memw, input logic irwr, input logic pcwr,
        input logic [1:0] pcsrc, input logic regw, input logic [1:0] regdst,
        input logic [1:0] wdsel, input logic srcb, input logic [1:0] ext,
        input logic [4:0] alu, input logic [2:0] st, input logic tr);
        return {mreq, memw, irwr, pcwr, pcsrc, regw, regdst, wdsel,
                srcb, ext, alu, st, tr};
    endfunction

    function automatic logic [22:0] fetch_v(input logic rdy);
        return ev(1, 0, rdy, rdy, 2'b00, 0, 2'b00, 2'b00, 0, 2'd0, 5'd0, 3'd0, 0);
    endfunction

    function automatic logic [22:0] dcd_v();
        return ev(0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'd0, 5'd0, 3'd1, 0);
    endfunction

    function automatic logic [22:0] err_v();
        return ev(0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'd0, 5'd0, 3'd7, 1);
    endfunction

    task automatic check(input string tag, input logic [22:0] got,
                         input logic [22:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %06h expected %06h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] fn,
                         input logic z);
        Op    = op;
        Funct = fn;
        Zero  = z;
    endtask

    // One cycle: drive mem_rdy, check outputs, advance to just past the edge.
    task automatic tick(input string tag, input logic rdy,
                        input logic [22:0] exp);
        mem_rdy = rdy;
        #1;
        check(tag, outs, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        check(tag, outs, 23'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        instr(6'h00, 6'h21, 1'b0);
        mem_rdy = 1'b1;
        #1;
        check("reset_outs", outs, 23'd0);
        @(posedge clk);
        #1;
        check("reset_hold", outs, 23'd0);
        rst = 1'b1;

        // addu: 0,1,2,4 then next fetch
        instr(6'h00, 6'h21, 1'b0);
        tick("addu_fetch", 1, fetch_v(1));
        tick("addu_dcd",   1, dcd_v());
        tick("addu_exe",   1, ev(0,0,0,0,2'b00,0,2'b00,2'b00,0,2'd0,5'd1,3'd2,0));
        tick("addu_wb",    1, ev(0,0,0,0,2'b00,1,2'b00,2'b00,0,2'd0,5'd1,3'd4,0));

        // subu: ALU SUB through EXE and WB
        instr(6'h00, 6'h23, 1'b0);
        tick("subu_fetch", 1, fetch_v(1));
        tick("subu_dcd",   1, dcd_v());
        tick("subu_exe",   1, ev(0,0,0,0,2'b00,0,2'b00,2'b00,0,2'd0,5'd2,3'd2,0));
        tick("subu_wb",    1, ev(0,0,0,0,2'b00,1,2'b00,2'b00,0,2'd0,5'd2,3'd4,0));

        // lw with 3 wait cycles in MEM: 8 cycles total
        instr(6'h23, 6'h00, 1'b0);
        tick("lw_fetch", 1, fetch_v(1));
        tick("lw_dcd",   1, dcd_v());
        tick("lw_exe",   1, ev(0,0,0,0,2'b00,0,2'b00,2'b00,1,2'd1,5'd1,3'd2,0));
        for (int i = 0; i < 3; i++)
            tick("lw_mem_wait", 0, ev(1,0,0,0,2'b00,0,2'b00,2'b00,1,2'd1,5'd1,3'd3,0));
        tick("lw_mem_rdy", 1, ev(1,0,0,0,2'b00,0,2'b00,2'b00,1,2'd1,5'd1,3'd3,0));
        tick("lw_wb",      1, ev(0,0,0,0,2'b00,1,2'b01,2'b01,1,2'd1,5'd1,3'd4,0));

        // beq taken
        instr(6'h04, 6'h00, 1'b1);
        tick("beq_t_fetch", 1, fetch_v(1));
        tick("beq_t_dcd",   1, dcd_v());
        tick("beq_t_br",    1, ev(0,0,0,1,2'b01,0,2'b00,2'b00,0,2'd0,5'd2,3'd5,0));

        // beq not taken
        instr(6'h04, 6'h00, 1'b0);
        tick("beq_n_fetch", 1, fetch_v(1));
        tick("beq_n_dcd",   1, dcd_v());
        tick("beq_n_br",    1, ev(0,0,0,0,2'b00,0,2'b00,2'b00,0,2'd0,5'd2,3'd5,0));

        // jal
        instr(6'h03, 6'h00, 1'b0);
        tick("jal_fetch", 1, fetch_v(1));
        tick("jal_dcd",   1, dcd_v());
        tick("jal_jmp",   1, ev(0,0,0,1,2'b10,1,2'b10,2'b10,0,2'd0,5'd0,3'd6,0));

        // j
        instr(6'h02, 6'h00, 1'b0);
        tick("j_fetch", 1, fetch_v(1));
        tick("j_dcd",   1, dcd_v());
        tick("j_jmp",   1, ev(0,0,0,1,2'b10,0,2'b00,2'b00,0,2'd0,5'd0,3'd6,0));

        // jr
        instr(6'h00, 6'h08, 1'b0);
        tick("jr_fetch", 1, fetch_v(1));
        tick("jr_dcd",   1, dcd_v());
        tick("jr_jmp",   1, ev(0,0,0,1,2'b11,0,2'b00,2'b00,0,2'd0,5'd0,3'd6,0));

        // sw, zero-wait: 4 cycles
        instr(6'h2B, 6'h00, 1'b0);
        tick("sw_fetch", 1, fetch_v(1));
        tick("sw_dcd",   1, dcd_v());
        tick("sw_exe",   1, ev(0,0,0,0,2'b00,0,2'b00,2'b00,1,2'd1,5'd1,3'd2,0));
        tick("sw_mem",   1, ev(1,1,0,0,2'b00,0,2'b00,2'b00,1,2'd1,5'd1,3'd3,0));

        // ori: OR with zero-extend, rt destination
        instr(6'h0D, 6'h00, 1'b0);
        tick("ori_fetch", 1, fetch_v(1));
        tick("ori_dcd",   1, dcd_v());
        tick("ori_exe",   1, ev(0,0,0,0,2'b00,0,2'b00,2'b00,1,2'd0,5'd4,3'd2,0));
        tick("ori_wb",    1, ev(0,0,0,0,2'b00,1,2'b01,2'b00,1,2'd0,5'd4,3'd4,0));

        // lui: rdy arrives on the 4th fetch cycle, the one that would trap
        instr(6'h0F, 6'h00, 1'b0);
        for (int i = 0; i < 3; i++)
            tick("lui_fetch_wait", 0, fetch_v(0));
        tick("lui_fetch_edge", 1, fetch_v(1));
        tick("lui_dcd",        1, dcd_v());
        tick("lui_exe",        1, ev(0,0,0,0,2'b00,0,2'b00,2'b00,1,2'd2,5'd8,3'd2,0));
        tick("lui_wb",         1, ev(0,0,0,0,2'b00,1,2'b01,2'b00,1,2'd2,5'd8,3'd4,0));

        // Watchdog in FETCH: 4 wait cycles, then ERR, sticky despite rdy
        instr(6'h00, 6'h21, 1'b0);
        for (int i = 0; i < 4; i++)
            tick("wd_fetch_wait", 0, fetch_v(0));
        for (int i = 0; i < 3; i++)
            tick("wd_err_sticky", 1, err_v());
        do_reset("wd_reset");
        tick("wd_restart", 1, fetch_v(1));

        // Illegal opcode traps from DCD
        instr(6'h3F, 6'h00, 1'b0);
        tick("ill_dcd", 1, dcd_v());
        tick("ill_err", 1, err_v());
        tick("ill_err_hold", 0, err_v());
        do_reset("ill_reset");

        // Watchdog in MEM; the fetch waits must not count toward it
        instr(6'h23, 6'h00, 1'b0);
        tick("wdm_fetch_wait", 0, fetch_v(0));
        tick("wdm_fetch_wait", 0, fetch_v(0));
        tick("wdm_fetch",      1, fetch_v(1));
        tick("wdm_dcd",        1, dcd_v());
        tick("wdm_exe",        1, ev(0,0,0,0,2'b00,0,2'b00,2'b00,1,2'd1,5'd1,3'd2,0));
        for (int i = 0; i < 4; i++)
            tick("wdm_mem_wait", 0, ev(1,0,0,0,2'b00,0,2'b00,2'b00,1,2'd1,5'd1,3'd3,0));
        tick("wdm_err", 1, err_v());
        do_reset("wdm_reset");

        // sw interrupted by reset mid-access
        instr(6'h2B, 6'h00, 1'b0);
        tick("swr_fetch", 1, fetch_v(1));
        tick("swr_dcd",   1, dcd_v());
        tick("swr_exe",   1, ev(0,0,0,0,2'b00,0,2'b00,2'b00,1,2'd1,5'd1,3'd2,0));
        tick("swr_mem",   0, ev(1,1,0,0,2'b00,0,2'b00,2'b00,1,2'd1,5'd1,3'd3,0));
        mem_rdy = 1'b1;
        do_reset("swr_reset");
        tick("swr_restart", 1, fetch_v(1));
        tick("swr_dcd2",    1, dcd_v());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the second-generation MIPS core. It replaces the single-cycle combinational decoder with a state machine that sequences fetch, decode, execute, memory and write-back over several cycles, sharing one ALU and one memory port. Memory accesses use a request/ready handshake with a parametrised watchdog, so the core tolerates variable-latency instruction and data memory. It sits between the instruction register (IR) and the datapath multiplexers and write enables in the core top.

## Interface
- TIMEOUT, 16: maximum cycles `mem_req` may wait for `mem_rdy` before the machine traps; 0 disables the watchdog.
- CNTW, 8: watchdog counter width; must satisfy 2^CNTW > TIMEOUT.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-low.
- Op  in  6  IR[31:26]; stable from DCD until the next FETCH handshake.
- Funct  in  6  IR[5:0].
- Zero  in  1  ALU zero flag.
- mem_rdy  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- MemW  out  1  store qualifier; valid with `mem_req`.
- IRWr  out  1  load IR.
- PCWr  out  1  write PC.
- PCSrc  out  2  00 = PC+4, 01 = branch target, 10 = jump {PC[31:28], IMM, 00}, 11 = RD1 (jr).
- RegW  out  1  register-file write.
- RegDst  out  2  00 = rd, 01 = rt, 10 = $31.
- WDSel  out  2  00 = ALU result, 01 = memory data, 10 = PC (already advanced to PC+4).
- ALUSrcB  out  1  0 = RD2, 1 = Imm32.
- EXTOp  out  2  0 = zero-extend, 1 = sign-extend, 2 = imm<<16.
- ALUOp  out  5  0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SLT, 6 SLL, 7 SRL, 8 LUI.
- state  out  3  current state, for debug.
- trap  out  1  sticky error flag.

## Operation
- States: FETCH=0, DCD=1, EXE=2, MEM=3, WB=4, BR=5, JMP=6, ERR=7.

Per-state behaviour:
- FETCH: `mem_req`=1, `MemW`=0. In the cycle `mem_rdy`=1, assert `IRWr`=1, `PCWr`=1, `PCSrc`=00, then go to DCD.
- DCD: no strobes. Next state by opcode:
  - Op=0 with Funct in {addu 0x21, subu 0x23, and 0x24, or 0x25, slt 0x2A, sll 0x00, srl 0x02}: go to EXE.
  - Op=0 with Funct jr (0x08): go to JMP.
  - addi 0x08, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B: go to EXE.
  - beq 0x04: go to BR.
  - j 0x02, jal 0x03: go to JMP.
  - Anything else: go to ERR.
- EXE: drive `ALUOp`, `ALUSrcB` and `EXTOp` for the instruction.
  - addi, lw and sw use ADD with sign-extend; ori uses OR with zero-extend; lui uses LUI with `EXTOp`=2.
  - lw and sw go to MEM; all others go to WB.
- MEM: `mem_req`=1, `MemW`=1 for sw only, ALU controls held from EXE. On `mem_rdy`, lw goes to WB and sw goes to FETCH.
- WB: `RegW`=1, ALU controls held.
  - R-type: `RegDst`=00, `WDSel`=00.
  - Immediate instructions: `RegDst`=01, `WDSel`=00.
  - lw: `RegDst`=01, `WDSel`=01.
  - Then go to FETCH.
- BR: `ALUOp`=SUB, `ALUSrcB`=0. If `Zero`=1, assert `PCWr`=1 with `PCSrc`=01. Then go to FETCH.
- JMP: `PCWr`=1.
  - j: `PCSrc`=10.
  - jal: `PCSrc`=10, plus `RegW`=1, `RegDst`=10, `WDSel`=10.
  - jr: `PCSrc`=11.
  - Then go to FETCH.
- ERR: all strobes 0 and `trap`=1. The machine leaves ERR only through reset.

Watchdog:
- The counter clears on entry to FETCH or MEM and increments each waiting cycle (`mem_req`=1 and `mem_rdy`=0).
- If TIMEOUT≠0 and the counter reaches TIMEOUT while still waiting, the next state is ERR.
- `mem_rdy` arriving in the same cycle the count hits TIMEOUT wins: the access completes normally.
- `mem_rdy` outside FETCH or MEM is ignored.

## Timing
- Outputs are a Moore decode of the registered state plus Op, Funct and Zero. No output depends combinationally on `mem_rdy`, except `IRWr` and `PCWr` in FETCH, which are qualified by `mem_rdy` in that cycle.
- Cycle counts with zero-wait memory (`mem_rdy` high in the first request cycle):
  - R-type and immediate instructions: 4.
  - lw: 5.
  - sw: 4.
  - beq, j, jal and jr: 3.
- Each wait cycle adds exactly one cycle.
- While `rst`=0, asynchronously: state=FETCH, counter=0, `trap`=0, and every output is forced to 0, including `mem_req`.
- The first `mem_req`=1 appears in the first cycle after `rst` deasserts.
- Reset asserted mid-access abandons the access immediately. No `PCWr`, `RegW` or `MemW` may be seen after the asynchronous assertion.

## Test plan
- R-type timing: addu (Op=0, Funct=0x21), `mem_rdy` tied 1 -> states 0,1,2,4,0; `RegW`=1 only in the WB cycle with `ALUOp`=1 and `RegDst`=00.
- lw with 3 wait cycles in MEM -> MEM held 4 cycles with `MemW`=0; WB follows with `WDSel`=01 and `RegDst`=01; 8 cycles total.
- beq, taken and not taken: Zero=1 -> `PCWr`=1 with `PCSrc`=01 in BR; Zero=0 -> `PCWr`=0 in BR; both return to FETCH after 3 cycles.
- jal -> JMP cycle shows `PCWr`=1, `PCSrc`=10, `RegW`=1, `RegDst`=10, `WDSel`=10.
- Watchdog with TIMEOUT=4, `mem_rdy` held 0 in FETCH -> ERR after 4 wait cycles, `trap`=1 and sticky; illegal Op=0x3F also traps from DCD.
- Mid-access reset: assert `rst`=0 during the MEM state of sw -> all outputs 0 immediately; after release the machine restarts in FETCH with `trap`=0.
